// File: rtl/clkdiv_root.sv
// Programmable integer clock divider feeding a clock root anchor buffer.
// Divisor changes and stop/start requests are applied only at period boundaries.
module clkdiv_root #(
  parameter int unsigned W         = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         div_wen,
  input  logic [W-1:0] div_wdata,
  output logic [W-1:0] div_current,
  output logic         div_pending,
  output logic         clk_out,
  output logic         rise_next,
  output logic         fall_next
);

  if (RESET_DIV == 1) begin : g_illegal_reset_div
    $error("clkdiv_root: RESET_DIV=1 is not a legal divisor");
  end

  localparam logic [W-1:0] RST_DIV = W'(RESET_DIV);
  localparam logic [W-1:0] RST_CNT = (RESET_DIV == 0) ? '0 : W'(RESET_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] div_pend_q, div_pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         clk_out_q, clk_out_d;

  logic         running;
  logic         boundary;
  logic [W-1:0] div_next;
  logic [W:0]   half;
  logic [W:0]   cnt_inc;

  always_comb begin
    running  = (div_act_q != '0);
    boundary = !running || (cnt_q == div_act_q - W'(1));
    div_next = pend_vld_q ? div_pend_q : div_act_q;
    // One extra bit keeps (N+1)>>1 exact for N = 2^W-1.
    half     = ({1'b0, div_act_q} + {{W{1'b0}}, 1'b1}) >> 1;
    cnt_inc  = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};

    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;

    if (boundary) begin
      div_act_d  = div_next;
      pend_vld_d = 1'b0;
      cnt_d      = '0;
      clk_out_d  = (div_next != '0);
    end else begin
      cnt_d     = cnt_inc[W-1:0];
      clk_out_d = (cnt_inc < half);
    end

    // Capture after the boundary update so a same-cycle write stays pending.
    if (div_wen) begin
      div_pend_d = (div_wdata == W'(1)) ? W'(2) : div_wdata;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= RST_CNT;
      div_act_q  <= RST_DIV;
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign div_current = div_act_q;
  assign div_pending = pend_vld_q;
  assign rise_next   = boundary && (div_next != '0);
  assign fall_next   = running && !boundary && (cnt_inc == half);

endmodule

// File: tb/tb_clkdiv_root.sv
// Bench for clkdiv_root: directed scenarios plus random writes, checked against
// a period-level model that queues the high/low pattern of each whole period.
module tb_clkdiv_root;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         div_wen;
  logic [W-1:0] div_wdata;
  logic [W-1:0] div_current;
  logic         div_pending;
  logic         clk_out;
  logic         rise_next;
  logic         fall_next;

  int tests;
  int fails;

  clkdiv_root #(.W(W), .RESET_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_wen     (div_wen),
    .div_wdata   (div_wdata),
    .div_current (div_current),
    .div_pending (div_pending),
    .clk_out     (clk_out),
    .rise_next   (rise_next),
    .fall_next   (fall_next)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: each started period pushes ceil(N/2) highs then floor(N/2) lows
  int unsigned m_act;
  int unsigned m_pend;
  bit          m_pvld;
  bit          m_out;
  bit          per_q[$];

  function automatic void model_reset();
    m_act  = 2;
    m_pend = 0;
    m_pvld = 1'b0;
    m_out  = 1'b0;
    per_q.delete();
  endfunction

  function automatic bit model_peek();
    int unsigned d;
    if (per_q.size() > 0) return per_q[0];
    d = m_pvld ? m_pend : m_act;
    return (d != 0);
  endfunction

  function automatic void model_edge(input bit wen, input int unsigned d);
    if (per_q.size() == 0) begin
      if (m_pvld) begin
        m_act  = m_pend;
        m_pvld = 1'b0;
      end
      if (m_act != 0) begin
        for (int i = 0; i < int'((m_act + 1) / 2); i++) per_q.push_back(1'b1);
        for (int i = 0; i < int'(m_act / 2); i++) per_q.push_back(1'b0);
      end
    end
    if (per_q.size() > 0) m_out = per_q.pop_front();
    else m_out = 1'b0;
    if (wen) begin
      m_pend = (d == 1) ? 2 : d;
      m_pvld = 1'b1;
    end
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit nxt;
    nxt = model_peek();
    check("clk_out", {31'd0, clk_out}, {31'd0, m_out});
    check("div_current", {24'd0, div_current}, m_act);
    check("div_pending", {31'd0, div_pending}, {31'd0, m_pvld});
    check("rise_next", {31'd0, rise_next}, {31'd0, (!m_out && nxt)});
    check("fall_next", {31'd0, fall_next}, {31'd0, (m_out && !nxt)});
  endtask

  // driver: inputs change 1 time unit after each rising edge
  task automatic cycle(input bit wen, input int unsigned d);
    div_wen   = wen;
    div_wdata = W'(d);
    @(posedge clk);
    model_edge(wen, d);
    #1;
    div_wen   = 1'b0;
    div_wdata = '0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  // advance until the model sits at cnt=pos of a div-n period
  task automatic wait_pos(input string tag, input int unsigned n, input int unsigned pos);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_act == n && per_q.size() == n - 1 - pos) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 0);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_high(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_out) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 0);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    div_wen   = 1'b0;
    div_wdata = '0;
    model_reset();

    #12;
    check_all();
    rst_n = 1'b1;

    // RESET_DIV=2: rises on first edge, toggles every edge
    cycle(1'b0, 0);
    check("first_rise", {31'd0, clk_out}, 32'd1);
    idle(7);

    // switch to 5
    cycle(1'b1, 5);
    idle(20);

    // running at 4, write 6 at cnt=1
    cycle(1'b1, 4);
    wait_pos("reach_div4_cnt1", 4, 1);
    cycle(1'b1, 6);
    idle(20);

    // stop while high, then restart at 3
    wait_high("reach_high");
    cycle(1'b1, 0);
    idle(12);
    check("stopped_low", {31'd0, clk_out}, 32'd0);
    cycle(1'b1, 3);
    check("restart_edge1", {31'd0, clk_out}, 32'd0);
    cycle(1'b0, 0);
    check("restart_edge2", {31'd0, clk_out}, 32'd1);
    idle(10);

    // back-to-back writes, last wins; then 1 clamps to 2
    cycle(1'b1, 7);
    cycle(1'b1, 9);
    cycle(1'b1, 3);
    idle(15);
    check("last_write_wins", {24'd0, div_current}, 32'd3);
    cycle(1'b1, 1);
    idle(10);
    check("clamp_1_to_2", {24'd0, div_current}, 32'd2);

    // widest divisor
    cycle(1'b1, 255);
    idle(300);

    // asynchronous reset mid-period of a div-6 high phase
    cycle(1'b1, 6);
    wait_pos("reach_div6_cnt2", 6, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_low", {31'd0, clk_out}, 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cycle(1'b0, 0);
    check("post_reset_rise", {31'd0, clk_out}, 32'd1);
    idle(6);

    // random writes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) cycle(1'b1, $urandom_range(0, 14));
      else cycle(1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
